fp_dot_acc_seq: RTL

- Sequential dot-product engine that drives a dw_fp_mac instance (combinational FMA) as its datapath.
- Accepts a stream of (a,b) operand pairs over a valid/ready handshake and feeds the running accumulator back as operand c.
- Returns one rounded result with accumulated status per job.
- Sits upstream of result buffering and downstream of the operand fetch stage.

---
 rtl/fp_dot_acc_seq.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_dot_acc_seq.sv
// Sequential floating-point dot-product engine.
// dw_fp_mac is a combinational fused multiply-add z = a*b + c with a single
// rounding and DW-layout status bits. Subnormal results are flushed to signed
// zero and flagged tiny+inexact. Subnormal operands are honoured only when
// ieee_compliance is nonzero; otherwise they are read as zero.
// fp_dot_acc_seq streams (a,b) pairs into that FMA, feeds the running sum back
// as c, and returns one registered result per job.

module dw_fp_mac #(
    parameter int sig_width       = 23,
    parameter int exp_width       = 8,
    parameter int ieee_compliance = 0
) (
    input  logic [sig_width+exp_width:0] a,
    input  logic [sig_width+exp_width:0] b,
    input  logic [sig_width+exp_width:0] c,
    input  logic [2:0]                   rnd,
    output logic [sig_width+exp_width:0] z,
    output logic [7:0]                   status
);
    localparam int SW   = sig_width;
    localparam int EW   = exp_width;
    localparam int W    = SW + EW + 1;
    localparam int M    = 2 * SW + 2;   // product significand width
    localparam int XW   = M + 3;        // plus guard, round and sticky bits
    localparam int MW   = M + 4;        // magnitude width after add/sub
    localparam int SUMW = M + 5;        // signed sum width
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;
    localparam logic [MW-1:0] MAG_ONE = MW'(1);

    logic [W-1:0]    op      [3];
    logic            op_sign [3];
    logic            op_nan  [3];
    logic            op_inf  [3];
    logic            op_zero [3];
    logic [SW:0]     op_mant [3];
    logic [EW-1:0]   op_exp  [3];

    assign op[0] = a;
    assign op[1] = b;
    assign op[2] = c;

    // Classify each operand and extract its significand with the hidden bit.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_decode
            logic [EW-1:0] e;
            logic [SW-1:0] f;
            logic          exp_zero;
            assign e            = op[gi][W-2:SW];
            assign f            = op[gi][SW-1:0];
            assign exp_zero     = (e == '0);
            assign op_sign[gi]  = op[gi][W-1];
            assign op_nan[gi]   = (&e) & (|f);
            assign op_inf[gi]   = (&e) & ~(|f);
            assign op_zero[gi]  = exp_zero & (~(|f) | (ieee_compliance == 0));
            assign op_mant[gi]  = op_zero[gi] ? '0 : {~exp_zero, f};
            assign op_exp[gi]   = exp_zero ? EW'(1) : e;
        end
    endgenerate

    logic          p_sign, p_zero, p_inf, any_nan, invalid, eff_sub;
    logic [M-1:0]  prod, c_ext, m_big, m_small;
    logic          c_big, s_big;
    int            f1, f2, f_big, f_small, diff;
    logic [XW-1:0] small_ext, shifted, lost;
    logic [SUMW-1:0] big_w, small_w, sum;
    logic          neg, r_sign;
    logic [MW-1:0] mag, norm;
    int            lead;

    assign p_sign  = op_sign[0] ^ op_sign[1];
    assign p_zero  = op_zero[0] | op_zero[1];
    assign p_inf   = (op_inf[0] | op_inf[1]) & ~p_zero;
    assign any_nan = op_nan[0] | op_nan[1] | op_nan[2];
    assign invalid = ((op_inf[0] | op_inf[1]) & p_zero)
                   | (p_inf & op_inf[2] & (p_sign ^ op_sign[2]));
    assign eff_sub = p_sign ^ op_sign[2];
    assign prod    = {{(M-SW-1){1'b0}}, op_mant[0]} * {{(M-SW-1){1'b0}}, op_mant[1]};
    assign c_ext   = {op_mant[2], {(M-SW-1){1'b0}}};

    // Pick the operand with the higher LSB weight and align the other under it.
    // Exponents are offset so both sides stay non-negative integers.
    always_comb begin
        f1      = int'(op_exp[0]) + int'(op_exp[1]) + 1;
        f2      = int'(op_exp[2]) + BIAS;
        c_big   = p_zero | (~op_zero[2] & (f2 >= f1));
        m_big   = c_big ? c_ext : prod;
        m_small = c_big ? prod : c_ext;
        f_big   = c_big ? f2 : f1;
        f_small = c_big ? f1 : f2;
        s_big   = c_big ? op_sign[2] : p_sign;
        diff    = f_big - f_small;
        if (diff < 0) diff = 0;
        if (diff > XW) diff = XW;
        small_ext  = {m_small, 3'b000};
        shifted    = small_ext >> diff;
        lost       = small_ext & ~({XW{1'b1}} << diff);
        shifted[0] = shifted[0] | (|lost);
        big_w      = {2'b00, m_big, 3'b000};
        small_w    = {2'b00, shifted};
        sum        = eff_sub ? (big_w - small_w) : (big_w + small_w);
        neg        = sum[SUMW-1];
        mag        = neg ? (~sum[SUMW-2:0] + MAG_ONE) : sum[SUMW-2:0];
        r_sign     = s_big ^ neg;
    end

    // Locate the leading one and left-justify the magnitude.
    always_comb begin
        lead = 0;
        for (int i = 0; i < MW; i++) begin
            if (mag[i]) lead = i;
        end
        norm = mag << (MW - 1 - lead);
    end

    logic [SW:0]   mant_r;
    logic          rbit, sbit, inc, to_inf;
    logic [SW+1:0] mant_inc;
    int            er, er_r;

    // Round the normalised significand according to the rounding mode.
    always_comb begin
        mant_r = norm[MW-1 -: SW+1];
        rbit   = norm[MW-2-SW];
        sbit   = |norm[MW-3-SW:0];
        case (rnd)
            3'd1:    inc = 1'b0;
            3'd2:    inc = ~r_sign & (rbit | sbit);
            3'd3:    inc = r_sign & (rbit | sbit);
            3'd4:    inc = rbit;
            3'd5:    inc = rbit | sbit;
            default: inc = rbit & (sbit | mant_r[0]);
        endcase
        case (rnd)
            3'd1:    to_inf = 1'b0;
            3'd2:    to_inf = ~r_sign;
            3'd3:    to_inf = r_sign;
            default: to_inf = 1'b1;
        endcase
        mant_inc = {1'b0, mant_r} + (SW+2)'(inc);
        er       = lead + f_big - BIAS - 2 * SW - 4;
        er_r     = er + (mant_inc[SW+1] ? 1 : 0);
    end

    // Select the special-case or rounded result and build the status byte.
    always_comb begin
        z      = '0;
        status = '0;
        if (any_nan || invalid) begin
            z         = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
            status[2] = invalid;
        end else if (p_inf) begin
            z         = {p_sign, {EW{1'b1}}, {SW{1'b0}}};
            status[1] = 1'b1;
        end else if (op_inf[2]) begin
            z         = {op_sign[2], {EW{1'b1}}, {SW{1'b0}}};
            status[1] = 1'b1;
        end else if (mag == '0) begin
            z         = {(eff_sub ? (rnd == 3'd3) : s_big), {(W-1){1'b0}}};
            status[0] = 1'b1;
        end else if (er < 1) begin
            z         = {r_sign, {(W-1){1'b0}}};
            status[0] = 1'b1;
            status[3] = 1'b1;
            status[5] = 1'b1;
        end else if (er_r >= EMAX) begin
            z         = to_inf ? {r_sign, {EW{1'b1}}, {SW{1'b0}}}
                               : {r_sign, EW'(EMAX - 1), {SW{1'b1}}};
            status[1] = to_inf;
            status[4] = 1'b1;
            status[5] = 1'b1;
        end else begin
            z         = {r_sign, EW'(er_r), (mant_inc[SW+1] ? {SW{1'b0}} : mant_inc[SW-1:0])};
            status[5] = rbit | sbit;
        end
    end
endmodule

module fp_dot_acc_seq #(
    parameter int inst_sig_width       = 23,
    parameter int inst_exp_width       = 8,
    parameter int inst_ieee_compliance = 0,
    parameter int LEN_W                = 8
) (
    input  logic                                  inst_clk,
    input  logic                                  inst_rst_n,
    input  logic                                  start_i,
    input  logic [LEN_W-1:0]                      len_i,
    input  logic [2:0]                            rnd_i,
    output logic                                  busy_o,
    input  logic [inst_sig_width+inst_exp_width:0] a_i,
    input  logic [inst_sig_width+inst_exp_width:0] b_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    output logic [inst_sig_width+inst_exp_width:0] z_o,
    output logic [7:0]                            status_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i
);
    localparam int W = inst_sig_width + inst_exp_width + 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     acc_reg, acc_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       rnd_reg, rnd_next;
    logic [3:0]       sticky_reg, sticky_next;
    logic [W-1:0]     z_reg, z_next;
    logic [7:0]       status_reg, status_next;

    logic [W-1:0]     mac_z;
    logic [7:0]       mac_status;
    logic [3:0]       step_sticky;

    dw_fp_mac #(
        .sig_width       (inst_sig_width),
        .exp_width       (inst_exp_width),
        .ieee_compliance (inst_ieee_compliance)
    ) u_mac (
        .a      (a_i),
        .b      (b_i),
        .c      (acc_reg),
        .rnd    (rnd_reg),
        .z      (mac_z),
        .status (mac_status)
    );

    assign step_sticky = sticky_reg | mac_status[5:2];
    assign z_o         = z_reg;
    assign status_o    = status_reg;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        rnd_next    = rnd_reg;
        sticky_next = sticky_reg;
        z_next      = z_reg;
        status_next = status_reg;
        busy_o      = (state_reg != IDLE);
        in_ready_o  = (state_reg == ACC);
        out_valid_o = (state_reg == DONE);
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    rnd_next    = rnd_i;
                    cnt_next    = len_i;
                    acc_next    = '0;
                    sticky_next = '0;
                    if (len_i == '0) begin
                        z_next      = '0;
                        status_next = 8'h01;
                        state_next  = DONE;
                    end else begin
                        state_next  = ACC;
                    end
                end
            end
            ACC: begin
                if (in_valid_i) begin
                    acc_next    = mac_z;
                    cnt_next    = cnt_reg - LEN_W'(1);
                    sticky_next = step_sticky;
                    if (cnt_reg == LEN_W'(1)) begin
                        z_next      = mac_z;
                        status_next = {mac_status[7:6], step_sticky, mac_status[1:0]};
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            rnd_reg    <= '0;
            sticky_reg <= '0;
            z_reg      <= '0;
            status_reg <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            rnd_reg    <= rnd_next;
            sticky_reg <= sticky_next;
            z_reg      <= z_next;
            status_reg <= status_next;
        end
    end
endmodule
